vga_pixel_fetch: RTL and testbench
==================================

// Module: vga_pixel_fetch
// PURPOSE
//  Pixel-fetch stage between the VGA timing generator and the video framebuffer RAM.
//  Consumes the generator's column/row counts and raw syncs; produces the framebuffer read address.
//  Captures the returned 3-bit colour and re-times Hs/Vs through a matched pipeline so sync and RGB stay aligned.
//  Supports 2^SCALE_SHIFT pixel replication and double buffering, with the buffer swapped only at frame start.
// PARAMETERS
//  H_ACTIVE      640   visible columns
//  V_ACTIVE      480   visible rows
//  SCALE_SHIFT   1     log2 pixel replication; FB_W=H_ACTIVE>>SCALE_SHIFT, FB_H=V_ACTIVE>>SCALE_SHIFT
//  READ_LATENCY  1     pixel ticks from address issue to iColor sampled (>=1)
//  ADDR_WIDTH    19    width of oColorAddress; 2*FB_W*FB_H must fit
// PORTS
//  Clock          in   1   system clock
//  Reset          in   1   asynchronous, active-high reset
//  iPixelEnable   in   1   pixel tick, one Clock cycle wide (generator's Clock/2 rate); all state advances only on ticks
//  iColumn        in   10  current column from timing generator, 0..799
//  iRow           in   10  current row from timing generator, 0..520
//  iHs            in   1   raw horizontal sync, active low
//  iVs            in   1   raw vertical sync, active low
//  iBufferSelect  in   1   requested display buffer, sampled at frame start
//  iColor         in   3   read data from framebuffer RAM
//  oColorAddress  out  ADDR_WIDTH  framebuffer read address (registered)
//  oReadEnable    out  1   address valid / RAM read strobe (registered)
//  oHs            out  1   aligned horizontal sync
//  oVs            out  1   aligned vertical sync
//  oRGB           out  3   aligned pixel colour, 0 in blanking
//  oFrameStart    out  1   one-Clock pulse on the tick where iColumn==0 && iRow==0
//  oActiveBuffer  out  1   buffer currently displayed
// BEHAVIOUR
//  Reset values: oColorAddress=0, oReadEnable=0, oRGB=0, oHs=1, oVs=1, oFrameStart=0, oActiveBuffer=0.
//  Reset also clears all pipeline stages (sync stages to 1) and forces state UNSYNCED.
//  FSM (advances on ticks only):
//   UNSYNCED -> RUNNING on the first tick with iColumn==0 && iRow==0.
//   In UNSYNCED: oReadEnable=0, oRGB=0; syncs still pass through the pipeline.
//  Frame start tick (col 0,row 0): pulse oFrameStart; oActiveBuffer<=iBufferSelect; rowBase<=0; x<=0.
//   This holds also in UNSYNCED. Buffer swaps never happen mid-frame.
//  active = RUNNING && iColumn<H_ACTIVE && iRow<V_ACTIVE; columns/rows beyond totals are blank.
//  Address generation is incremental, no multiplier:
//   x advances every 2^SCALE_SHIFT active columns and resets at column 0.
//   rowBase += FB_W once per 2^SCALE_SHIFT rows, on the tick at column H_ACTIVE.
//  Result must equal (oActiveBuffer?FB_W*FB_H:0) + (iRow>>S)*FB_W + (iColumn>>S).
//  Sampled at tick T: oColorAddress/oReadEnable update at tick T. oColorAddress holds its last value when not active.
//  iColor is sampled at tick T+READ_LATENCY.
//   If the delayed active flag is 1, oRGB<=iColor; otherwise oRGB<=0.
//  iHs/iVs/active pass through READ_LATENCY+1 tick-enabled stages; oHs/oVs/oRGB change on the same tick.
//   Sync pulse widths and positions are unchanged, only delayed.
//  No tick: every register holds its value.
//  Reset mid-frame: outputs return to reset values immediately; RUNNING resumes at the next frame start.
// TESTING
//  1) Reset, free-run generator 2 frames -> oFrameStart once per 800*521 ticks; oReadEnable=0 before first frame start.
//  2) S=1, buffer0: (col 0,row 0)->addr 0; (col 3,row 0)->1; (col 0,row 2)->320; (col 639,row 479)->76799.
//  3) iBufferSelect=1 asserted mid-frame -> oActiveBuffer flips only at next frame start; (col 0,row 0)->addr 76800.
//  4) RAM model latency 1, data=addr[2:0]:
//     oRGB matches at tick T+1; hsync low 96 ticks, delayed exactly 2 ticks vs iHs.
//     oRGB=0 in cols 640..799 and rows 480..520.
//  5) Reset pulsed at col 100,row 50 -> oHs=oVs=1, oRGB=0 at once; oReadEnable stays 0 until next col 0,row 0.
//  6) iPixelEnable held low 10 cycles mid-line -> all outputs frozen; resume with no skipped address.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: turns timing-generator counts into framebuffer read addresses and re-times sync/colour.
module vga_pixel_fetch #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int SCALE_SHIFT  = 1,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 19
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPixelEnable,
  input  logic [9:0]            iColumn,
  input  logic [9:0]            iRow,
  input  logic                  iHs,
  input  logic                  iVs,
  input  logic                  iBufferSelect,
  input  logic [2:0]            iColor,
  output logic [ADDR_WIDTH-1:0] oColorAddress,
  output logic                  oReadEnable,
  output logic                  oHs,
  output logic                  oVs,
  output logic [2:0]            oRGB,
  output logic                  oFrameStart,
  output logic                  oActiveBuffer
);
  localparam int FB_W = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H = V_ACTIVE >> SCALE_SHIFT;
  localparam int SW = SCALE_SHIFT + 1;
  localparam logic [ADDR_WIDTH-1:0] BUF_SIZE = ADDR_WIDTH'(FB_W * FB_H);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_W);
  localparam logic [9:0] H_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_END = 10'(V_ACTIVE);
  localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_SHIFT) - 1);
  typedef enum logic {UNSYNCED, RUNNING} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] x, rowBase, xCur, baseCur;
  logic [SW-1:0] colSub, rowSub, subCur;
  logic [READ_LATENCY:0] hsPipe, vsPipe;
  logic [READ_LATENCY-1:0] actPipe;
  logic frameStart, active, bufCur, colWrap;
  // The frame-start tick already uses the new buffer and a zeroed row base.
  always_comb begin
    frameStart = iColumn == 10'd0 && iRow == 10'd0;
    active = (state == RUNNING || frameStart) && iColumn < H_END && iRow < V_END;
    bufCur = frameStart ? iBufferSelect : oActiveBuffer;
    xCur = iColumn == 10'd0 ? '0 : x;
    subCur = iColumn == 10'd0 ? '0 : colSub;
    baseCur = frameStart ? '0 : rowBase;
    colWrap = subCur == SUB_MAX;
  end
  assign oHs = hsPipe[READ_LATENCY];
  assign oVs = vsPipe[READ_LATENCY];
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= UNSYNCED;
      x <= '0;
      rowBase <= '0;
      colSub <= '0;
      rowSub <= '0;
      hsPipe <= '1;
      vsPipe <= '1;
      actPipe <= '0;
      oColorAddress <= '0;
      oReadEnable <= 1'b0;
      oRGB <= 3'd0;
      oFrameStart <= 1'b0;
      oActiveBuffer <= 1'b0;
    end else begin
      oFrameStart <= iPixelEnable && frameStart;
      if (iPixelEnable) begin
        if (frameStart) begin
          state <= RUNNING;
          oActiveBuffer <= iBufferSelect;
          rowBase <= '0;
          rowSub <= '0;
        end else if (iColumn == H_END) begin
          rowSub <= rowSub == SUB_MAX ? '0 : rowSub + 1'b1;
          rowBase <= rowSub == SUB_MAX ? rowBase + ROW_STEP : rowBase;
        end
        if (iColumn < H_END) begin
          colSub <= colWrap ? '0 : subCur + 1'b1;
          x <= colWrap ? xCur + 1'b1 : xCur;
        end
        oReadEnable <= active;
        if (active) oColorAddress <= (bufCur ? BUF_SIZE : '0) + baseCur + xCur;
        hsPipe <= {hsPipe[READ_LATENCY-1:0], iHs};
        vsPipe <= {vsPipe[READ_LATENCY-1:0], iVs};
        actPipe <= READ_LATENCY'({actPipe, active});
        oRGB <= actPipe[READ_LATENCY-1] ? iColor : 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: randomized generator/RAM stimulus against a formula-based reference model.
module tb_vga_pixel_fetch;
  logic clk = 1'b0, rst = 1'b1, pe = 1'b0, hs = 1'b1, vs = 1'b1, sel = 1'b0;
  logic [9:0] col = '0, row = '0;
  logic [18:0] addr;
  logic [2:0] rgb, color;
  logic re, oHs, oVs, fs, ab;
  int checks = 0, errors = 0, fsCycles = 0;
  bit synced, mBuf, mRe, prevAct, prevHs, prevVs;
  int mAddr, prevAddr, hsRun;

  always #5 clk = ~clk;
  assign color = addr[2:0];

  vga_pixel_fetch dut (
    .Clock(clk), .Reset(rst), .iPixelEnable(pe), .iColumn(col), .iRow(row),
    .iHs(hs), .iVs(vs), .iBufferSelect(sel), .iColor(color),
    .oColorAddress(addr), .oReadEnable(re), .oHs(oHs), .oVs(oVs),
    .oRGB(rgb), .oFrameStart(fs), .oActiveBuffer(ab)
  );

  always @(negedge clk) if (fs === 1'b1) fsCycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    synced = 0; mBuf = 0; mRe = 0; prevAct = 0; mAddr = 0; prevAddr = 0;
    prevHs = 1; prevVs = 1; hsRun = 0;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "Addr"}, addr, 0);
    check({tag, "Re"}, re, 0);
    check({tag, "Rgb"}, rgb, 0);
    check({tag, "Hs"}, oHs, 1);
    check({tag, "Vs"}, oVs, 1);
    check({tag, "Fs"}, fs, 0);
    check({tag, "Buf"}, ab, 0);
  endtask

  task automatic doTick(input int c, input int r);
    bit fsE, act;
    int eRgb, eHs, eVs;
    @(negedge clk);
    col = 10'(c); row = 10'(r);
    hs = !(c >= 656 && c < 752);
    vs = !(r == 490 || r == 491);
    pe = 1'b1;
    @(posedge clk);
    #1;
    pe = 1'b0;
    fsE = c == 0 && r == 0;
    if (fsE) begin synced = 1; mBuf = sel; end
    act = synced && c < 640 && r < 480;
    eRgb = prevAct ? prevAddr % 8 : 0;
    eHs = prevHs; eVs = prevVs;
    if (act) mAddr = (mBuf ? 76800 : 0) + (r / 2) * 320 + c / 2;
    mRe = act;
    prevAct = act; prevAddr = mAddr; prevHs = hs; prevVs = vs;
    check("addr", addr, mAddr);
    check("readEnable", re, mRe);
    check("rgb", rgb, eRgb);
    check("hs", oHs, eHs);
    check("vs", oVs, eVs);
    check("frameStart", fs, fsE);
    check("activeBuffer", ab, mBuf);
    if (synced && c == 0 && r == 0) check("addr00", addr, mBuf ? 76800 : 0);
    if (synced && !mBuf && c == 3 && r == 0) check("addr30", addr, 1);
    if (synced && !mBuf && c == 0 && r == 2) check("addr02", addr, 320);
    if (synced && !mBuf && c == 639 && r == 479) check("addrLast", addr, 76799);
    if (oHs === 1'b0) hsRun++;
    else begin
      if (hsRun > 0) check("hsLowWidth", hsRun, 96);
      hsRun = 0;
    end
    repeat ($urandom_range(1, 2)) @(posedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    pe = 1'b0;
    rst = 1'b1;
    #1;
    checkResetState("midRst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic stall();
    logic [31:0] snap;
    snap = {addr[18:0], re, oHs, oVs, rgb, ab, fs};
    repeat (10) begin
      @(posedge clk);
      #1;
      check("stall", {addr[18:0], re, oHs, oVs, rgb, ab, fs}, snap);
    end
  endtask

  function automatic bit fullRow(input int r);
    return r == 0 || r == 1 || r == 2 || r == 3 || r == 50 || r == 479 || r == 490;
  endfunction

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetState("rst");
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b1;
    for (int c = 0; c < 800; c++) doTick(c, 479);
    doTick(640, 520);
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 521; r++) begin
        sel = r == 0 ? (f == 0 ? 1'b0 : f == 1 ? 1'b1 : 1'($urandom))
            : (f == 0 && r == 1) ? 1'b1 : 1'($urandom);
        if (fullRow(r)) begin
          for (int c = 0; c < 800; c++) begin
            if (f == 2 && r == 50 && c == 100) doReset();
            doTick(c, r);
            if (f == 0 && r == 1 && c == 300) stall();
          end
        end else doTick(640, r);
      end
    end
    sel = 1'($urandom);
    for (int c = 0; c < 16; c++) doTick(c, 0);
    repeat (2) @(posedge clk);
    check("frameStartCount", fsCycles, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
